div_unit: RTL



---
 rtl/div_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient}; stalls EX through busy_o while iterating.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic [1:0]         state_o
);

    // Handshake: start_i is held high until ready_o is seen, then dropped;
    // END releases to IDLE only on start_i=0, and a new start needs IDLE.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_signed;
    logic               r_neg1;
    logic               r_neg2;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_abort;

    // r_dq starts as the dividend and fills with quotient bits from the LSB.
    assign w_trial    = {r_rem, r_dq[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_divisor};
    assign w_ge       = (w_trial >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

    assign w_quot_fix = (r_signed && (r_neg1 ^ r_neg2)) ? -r_dq : r_dq;
    assign w_rem_fix  = (r_signed && r_neg1) ? -r_rem : r_rem;

    assign w_abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    assign w_abort = annul_i || !start_i;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (start_i && !annul_i) begin
                        r_dq      <= w_abs1;
                        r_divisor <= w_abs2;
                        r_signed  <= signed_i;
                        r_neg1    <= opdata1_i[WIDTH-1];
                        r_neg2    <= opdata2_i[WIDTH-1];
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_state   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state  <= S_END;
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else if (r_cnt == LAST) begin
                        r_state  <= S_END;
                        r_result <= {w_rem_fix, w_quot_fix};
                        r_ready  <= 1'b1;
                    end else begin
                        r_rem <= w_rem_next;
                        r_dq  <= {r_dq[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_END: begin
                    // annul_i is deliberately ignored here.
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;
    assign busy_o   = (r_state == S_BYZERO) || (r_state == S_ON);
    assign state_o  = r_state;

endmodule
